// File: rtl/uart_bridge_pkg.sv
// Shared constants for the AXI4-Lite UART TX bridge: register offsets,
// response codes and the serializer state encoding.
package uart_bridge_pkg;

    localparam logic [11:0] OFF_TXDATA = 12'h000;
    localparam logic [11:0] OFF_STATUS = 12'h004;
    localparam logic [11:0] OFF_DIV    = 12'h008;
    localparam logic [11:0] OFF_CTRL   = 12'h00C;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } ser_state_e;

    // A divisor of zero still yields one clock per bit.
    function automatic logic [15:0] bit_clocks(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with power-of-two depth; pointers wrap naturally and the
// occupancy counter is one bit wider than the pointers.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     count
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              do_push;
    logic              do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Clear has priority over a same-cycle push or pop.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/axi4_uart_tx_fifo_bridge.sv
// AXI4-Lite register block feeding an 8N1 UART transmitter through a TX FIFO.
// The serializer latches the bit period at each frame start.
module axi4_uart_tx_fifo_bridge
    import uart_bridge_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h9000_0000,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] DIV_RESET  = 16'd217
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    output logic        uart_tx,
    output logic        irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic        bvalid_q, rvalid_q, txie_q, tx_q;
    logic [1:0]  bresp_q, rresp_q, rresp_d;
    logic [31:0] rdata_q, rdata_d;
    logic [15:0] div_q, cnt_q, nbit_q;
    logic [2:0]  bit_q;
    logic [7:0]  shreg_q;
    ser_state_e  state_q;

    logic          fifo_push, fifo_clear, fifo_full, fifo_empty;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;
    logic          wr_fire, rd_fire, w_hit, r_hit, w_is_tx, w_is_div, w_is_ctrl, w_err;
    logic          busy, bit_end, start_frame;
    logic [31:0]   status_word;
    logic          unused_ok;

    assign wr_fire = awvalid & wvalid & ~bvalid_q;
    assign rd_fire = arvalid & ~rvalid_q;
    assign awready = wr_fire & ~rst;
    assign wready  = wr_fire & ~rst;
    assign arready = rd_fire & ~rst;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign rvalid  = rvalid_q;
    assign rresp   = rresp_q;
    assign rdata   = rdata_q;
    assign uart_tx = tx_q;
    assign irq     = txie_q & (fifo_count <= CW'(1));

    assign w_hit     = (awaddr[31:12] == BASE_ADDR[31:12]);
    assign r_hit     = (araddr[31:12] == BASE_ADDR[31:12]);
    assign w_is_tx   = w_hit & (awaddr[11:0] == OFF_TXDATA);
    assign w_is_div  = w_hit & (awaddr[11:0] == OFF_DIV);
    assign w_is_ctrl = w_hit & (awaddr[11:0] == OFF_CTRL);
    // STATUS is absent from the writable set, so writes to it fall into the error path.
    assign w_err      = ~(w_is_tx | w_is_div | w_is_ctrl) | (w_is_tx & wstrb[0] & fifo_full);
    assign fifo_push  = wr_fire & w_is_tx & wstrb[0] & ~fifo_full;
    assign fifo_clear = wr_fire & w_is_ctrl & wstrb[0] & wdata[1];

    assign busy        = (state_q != ST_IDLE) | ~fifo_empty;
    assign status_word = {16'h0, 8'(fifo_count), 5'h0, busy, fifo_empty, fifo_full};
    assign bit_end     = (cnt_q == nbit_q - 16'd1);
    // STOP hands straight to START so consecutive frames have no idle gap.
    assign start_frame = ~fifo_empty & ((state_q == ST_IDLE) | ((state_q == ST_STOP) & bit_end));
    assign unused_ok   = &{1'b0, wdata[31:16], wstrb[3:2]};

    sync_fifo #(.DATA_W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (fifo_clear),
        .push  (fifo_push),
        .din   (wdata[7:0]),
        .pop   (start_frame),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        rdata_d = '0;
        rresp_d = RESP_OKAY;
        if (!r_hit) begin
            rresp_d = RESP_SLVERR;
        end else begin
            case (araddr[11:0])
                OFF_TXDATA: rdata_d = '0;
                OFF_STATUS: rdata_d = status_word;
                OFF_DIV:    rdata_d = {16'h0, div_q};
                OFF_CTRL:   rdata_d = {31'h0, txie_q};
                default:    rresp_d = RESP_SLVERR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
            div_q    <= DIV_RESET;
            txie_q   <= 1'b0;
        end else begin
            if (wr_fire) begin
                bvalid_q <= 1'b1;
                bresp_q  <= w_err ? RESP_SLVERR : RESP_OKAY;
            end else if (bvalid_q && bready) begin
                bvalid_q <= 1'b0;
            end
            if (wr_fire && w_is_div) begin
                if (wstrb[0]) div_q[7:0]  <= wdata[7:0];
                if (wstrb[1]) div_q[15:8] <= wdata[15:8];
            end
            if (wr_fire && w_is_ctrl && wstrb[0]) begin
                txie_q <= wdata[0];
            end
            if (rd_fire) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rdata_d;
                rresp_q  <= rresp_d;
            end else if (rvalid_q && rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tx_q    <= 1'b1;
            cnt_q   <= '0;
            nbit_q  <= 16'd1;
            bit_q   <= '0;
            shreg_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    tx_q <= 1'b1;
                    if (start_frame) begin
                        state_q <= ST_START;
                        tx_q    <= 1'b0;
                        cnt_q   <= '0;
                        nbit_q  <= bit_clocks(div_q);
                        shreg_q <= fifo_dout;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        state_q <= ST_DATA;
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        tx_q    <= shreg_q[0];
                        shreg_q <= shreg_q >> 1;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (bit_q == 3'd7) begin
                            state_q <= ST_STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            tx_q    <= shreg_q[0];
                            shreg_q <= shreg_q >> 1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (start_frame) begin
                            state_q <= ST_START;
                            tx_q    <= 1'b0;
                            nbit_q  <= bit_clocks(div_q);
                            shreg_q <= fifo_dout;
                        end else begin
                            state_q <= ST_IDLE;
                            tx_q    <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_uart_tx_fifo_bridge.sv
// Directed bench for the AXI4-Lite UART TX bridge: register access, frame
// timing, response back-pressure, FIFO overflow, flush and mid-frame reset.
module tb_axi4_uart_tx_fifo_bridge;

  localparam logic [31:0] BASE = 32'h9000_0000;
  localparam logic [31:0] A_TX = BASE + 32'h0;
  localparam logic [31:0] A_ST = BASE + 32'h4;
  localparam logic [31:0] A_DV = BASE + 32'h8;
  localparam logic [31:0] A_CT = BASE + 32'hC;

  logic        clk, rst;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, uart_tx, irq;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int checks;
  int errors;
  logic [7:0] exp_q[$];

  axi4_uart_tx_fifo_bridge dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .uart_tx(uart_tx), .irq(irq)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp, output int lat);
    int n;
    bit done;
    @(negedge clk);
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    n = 0; done = 1'b0;
    while (!done && n < 50) begin
      #1;
      if (awready && wready) done = 1'b1;
      else begin @(negedge clk); n++; end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL aw_handshake: got no awready, required awready=1 within 50 cycles");
    end
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    lat = 1;
    while (!bvalid && lat < 50) begin @(negedge clk); lat++; end
    resp = bresp;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp,
                          output int lat);
    int n;
    bit done;
    @(negedge clk);
    araddr = addr; arvalid = 1'b1;
    n = 0; done = 1'b0;
    while (!done && n < 50) begin
      #1;
      if (arready) done = 1'b1;
      else begin @(negedge clk); n++; end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL ar_handshake: got no arready, required arready=1 within 50 cycles");
    end
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0;
    lat = 1;
    while (!rvalid && lat < 50) begin @(negedge clk); lat++; end
    data = rdata; resp = rresp;
  endtask

  task automatic test_reset();
    rst = 1'b1; awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    awaddr = A_DV; araddr = A_ST; wdata = 32'h5; wstrb = 4'hF;
    bready = 1'b1; rready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
      errors++; $display("FAIL reset_handshake: got %b, required 00000", {awready, wready, arready, bvalid, rvalid});
    end
    checks++;
    if ({bresp, rresp} !== 4'b0) begin
      errors++; $display("FAIL reset_resp: got %b, required 0000", {bresp, rresp});
    end
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h, required 0", rdata); end
    checks++;
    if (uart_tx !== 1'b1 || irq !== 1'b0) begin
      errors++; $display("FAIL reset_tx_irq: got tx=%b irq=%b, required tx=1 irq=0", uart_tx, irq);
    end
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_regs();
    logic [31:0] d; logic [1:0] r; int l;
    axi_read(A_ST, d, r, l);
    checks++;
    if (d !== 32'h2 || r !== 2'b00 || l !== 1) begin
      errors++; $display("FAIL status_after_reset: got %h/%b lat %0d, required 00000002/00 lat 1", d, r, l);
    end
    axi_read(BASE + 32'h10, d, r, l);
    checks++;
    if (d !== 32'h0 || r !== 2'b10) begin
      errors++; $display("FAIL read_unmapped: got %h/%b, required 0/10", d, r);
    end
    axi_write(A_ST, 32'hFFFF_FFFF, 4'hF, r, l);
    checks++;
    if (r !== 2'b10 || l !== 1) begin
      errors++; $display("FAIL write_status: got %b lat %0d, required 10 lat 1", r, l);
    end
    axi_read(A_DV, d, r, l);
    checks++;
    if (d !== 32'd217 || r !== 2'b00) begin
      errors++; $display("FAIL div_reset: got %h/%b, required 000000d9/00", d, r);
    end
    axi_write(A_DV, 32'h0000_1234, 4'b0001, r, l);
    axi_read(A_DV, d, r, l);
    checks++;
    if (d !== 32'h34) begin errors++; $display("FAIL div_bytestrobe: got %h, required 00000034", d); end
    axi_write(A_TX, 32'h0000_00AA, 4'b0000, r, l);
    checks++;
    if (r !== 2'b00) begin errors++; $display("FAIL push_nostrobe_resp: got %b, required 00", r); end
    axi_read(A_ST, d, r, l);
    checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL push_nostrobe_status: got %h, required 00000002", d); end
    axi_read(A_CT, d, r, l);
    checks++;
    if (d !== 32'h0 || r !== 2'b00) begin errors++; $display("FAIL ctrl_reset: got %h/%b, required 0/00", d, r); end
  endtask

  task automatic test_single_frame();
    logic [1:0] r; int l;
    logic [9:0] frame;
    logic e;
    frame = {1'b1, 8'h55, 1'b0};
    axi_write(A_DV, 32'd4, 4'hF, r, l);
    axi_write(A_TX, 32'h55, 4'h1, r, l);
    checks++;
    if (r !== 2'b00 || l !== 1) begin
      errors++; $display("FAIL frame_bresp: got %b lat %0d, required 00 lat 1", r, l);
    end
    checks++;
    if (uart_tx !== 1'b1) begin errors++; $display("FAIL frame_idle_t1: got %b, required 1", uart_tx); end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      e = frame[i / 4];
      checks++;
      if (uart_tx !== e) begin
        errors++; $display("FAIL frame_0x55 clk %0d: got %b, required %b", i, uart_tx, e);
      end
    end
  endtask

  task automatic test_bready_hold();
    logic [31:0] d; logic [1:0] r; int l;
    bready = 1'b0;
    axi_write(A_DV, 32'd7, 4'hF, r, l);
    awaddr = A_DV; wdata = 32'd9; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (bvalid !== 1'b1 || awready !== 1'b0) begin
        errors++; $display("FAIL bready_hold cycle %0d: got bvalid=%b awready=%b, required 1/0", i, bvalid, awready);
      end
      @(negedge clk);
    end
    bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin
      errors++; $display("FAIL bready_release: got bvalid=%b awready=%b wready=%b, required 0/1/1", bvalid, awready, wready);
    end
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    checks++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      errors++; $display("FAIL second_write_resp: got bvalid=%b bresp=%b, required 1/00", bvalid, bresp);
    end
    axi_read(A_DV, d, r, l);
    checks++;
    if (d !== 32'd9) begin errors++; $display("FAIL second_write_div: got %h, required 00000009", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic [1:0] r; int l; int n;
    logic [7:0] b; logic [9:0] frame; logic s0, s1;
    axi_write(A_DV, 32'd217, 4'hF, r, l);
    axi_write(A_TX, 32'hFF, 4'h1, r, l);
    checks++;
    if (r !== 2'b00) begin errors++; $display("FAIL b2b_first_push: got %b, required 00", r); end
    axi_write(A_DV, 32'd2, 4'hF, r, l);
    for (int i = 0; i < 16; i++) begin
      b = 8'(i * 37 + 11);
      axi_write(A_TX, {24'h0, b}, 4'h1, r, l);
      checks++;
      if (r !== 2'b00) begin errors++; $display("FAIL b2b_push %0d: got %b, required 00", i, r); end
      exp_q.push_back(b);
    end
    axi_read(A_ST, d, r, l);
    checks++;
    if (d !== 32'h0000_1005) begin errors++; $display("FAIL b2b_status_full: got %h, required 00001005", d); end
    axi_write(A_TX, 32'hA5, 4'h1, r, l);
    checks++;
    if (r !== 2'b10) begin errors++; $display("FAIL b2b_overflow: got %b, required 10", r); end
    axi_read(A_ST, d, r, l);
    checks++;
    if (d !== 32'h0000_1005) begin errors++; $display("FAIL b2b_overflow_noeffect: got %h, required 00001005", d); end
    n = 0;
    while (uart_tx !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    while (uart_tx !== 1'b0 && n < 6000) begin @(negedge clk); n++; end
    checks++;
    if (uart_tx !== 1'b0) begin errors++; $display("FAIL b2b_second_start: got %b, required 0 within 6000 cycles", uart_tx); end
    while (exp_q.size() > 0) begin
      b = exp_q.pop_front();
      frame = {1'b1, b, 1'b0};
      for (int k = 0; k < 10; k++) begin
        s0 = uart_tx; @(negedge clk);
        s1 = uart_tx; @(negedge clk);
        checks++;
        if (s0 !== frame[k] || s1 !== frame[k]) begin
          errors++; $display("FAIL b2b_serial byte %h bit %0d: got %b%b, required %b%b", b, k, s0, s1, frame[k], frame[k]);
        end
      end
    end
    n = 0;
    for (int i = 0; i < 30; i++) begin if (uart_tx !== 1'b1) n++; @(negedge clk); end
    checks++;
    if (n != 0) begin errors++; $display("FAIL b2b_idle_after: got %0d low cycles, required 0", n); end
    axi_read(A_ST, d, r, l);
    checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL b2b_drained: got %h, required 00000002", d); end
  endtask

  task automatic test_flush();
    logic [31:0] d; logic [1:0] r; int l; int n;
    axi_write(A_DV, 32'd4, 4'hF, r, l);
    for (int i = 0; i < 3; i++) axi_write(A_TX, 32'h00, 4'h1, r, l);
    axi_write(A_CT, 32'h1, 4'h1, r, l);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL flush_irq_before: got %b, required 0", irq); end
    axi_write(A_CT, 32'h3, 4'h1, r, l);
    checks++;
    if (irq !== 1'b1 || uart_tx !== 1'b0) begin
      errors++; $display("FAIL flush_t1: got irq=%b tx=%b, required irq=1 tx=0", irq, uart_tx);
    end
    axi_read(A_ST, d, r, l);
    checks++;
    if (d !== 32'h6) begin errors++; $display("FAIL flush_status: got %h, required 00000006", d); end
    axi_read(A_CT, d, r, l);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL flush_ctrl_readback: got %h, required 00000001", d); end
    n = 0;
    while (uart_tx !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (uart_tx !== 1'b1) begin errors++; $display("FAIL flush_frame_end: got %b, required 1 within 100 cycles", uart_tx); end
    n = 0;
    for (int i = 0; i < 60; i++) begin @(negedge clk); if (uart_tx !== 1'b1) n++; end
    checks++;
    if (n != 0) begin errors++; $display("FAIL flush_no_more_frames: got %0d low cycles, required 0", n); end
    axi_read(A_ST, d, r, l);
    checks++;
    if (d !== 32'h2 || irq !== 1'b1) begin
      errors++; $display("FAIL flush_final: got status %h irq %b, required 00000002 irq 1", d, irq);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] d; logic [1:0] r; int l; int n;
    axi_write(A_DV, 32'd4, 4'hF, r, l);
    axi_write(A_TX, 32'h00, 4'h1, r, l);
    axi_write(A_TX, 32'h00, 4'h1, r, l);
    repeat (6) @(negedge clk);
    checks++;
    if (uart_tx !== 1'b0) begin errors++; $display("FAIL midframe_data_low: got %b, required 0", uart_tx); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (uart_tx !== 1'b1) begin errors++; $display("FAIL midframe_tx_after_reset: got %b, required 1", uart_tx); end
    axi_read(A_ST, d, r, l);
    checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL midframe_status: got %h, required 00000002", d); end
    axi_read(A_DV, d, r, l);
    checks++;
    if (d !== 32'd217) begin errors++; $display("FAIL midframe_div: got %h, required 000000d9", d); end
    axi_read(A_CT, d, r, l);
    checks++;
    if (d !== 32'h0 || irq !== 1'b0) begin
      errors++; $display("FAIL midframe_ctrl: got %h irq %b, required 0 irq 0", d, irq);
    end
    n = 0;
    for (int i = 0; i < 50; i++) begin @(negedge clk); if (uart_tx !== 1'b1) n++; end
    checks++;
    if (n != 0) begin errors++; $display("FAIL midframe_fifo_discarded: got %0d low cycles, required 0", n); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    bready = 1'b1; rready = 1'b1;
    test_reset();
    test_regs();
    test_single_frame();
    test_bready_hold();
    test_back_to_back();
    test_flush();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
